// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the EX-stage operand muxes.
// Shadows the EX/MEM destination registers, registers operand selects, and raises stall/flush controls.
module fwd_hazard_ctrl #(
    parameter int RAW  = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            ex_redirect,
    input  logic            mem_stall,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_id,
    output logic            flush_ex,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic [CNTW-1:0] stall_cnt
);

    logic            ex_v_q,  ex_v_d;
    logic [RAW-1:0]  ex_rd_q, ex_rd_d;
    logic            ex_we_q, ex_we_d;
    logic            ex_ld_q, ex_ld_d;
    logic            mem_v_q,  mem_v_d;
    logic [RAW-1:0]  mem_rd_q, mem_rd_d;
    logic            mem_we_q, mem_we_d;
    logic [1:0]      fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]      fwd_b_sel_q, fwd_b_sel_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic            load_use;

    // The EX producer is younger than the MEM producer, so it is checked first.
    function automatic logic [1:0] select_src(
        input logic           use_x,
        input logic [RAW-1:0] rs,
        input logic           ex_v,
        input logic           ex_we,
        input logic [RAW-1:0] ex_rd,
        input logic           mem_v,
        input logic           mem_we,
        input logic [RAW-1:0] mem_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_x && ex_v && ex_we && (ex_rd != '0) && (rs == ex_rd)) begin
            sel = 2'b10;
        end else if (use_x && mem_v && mem_we && (mem_rd != '0) && (rs == mem_rd)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = id_valid && ex_v_q && ex_ld_q && ex_we_q && (ex_rd_q != '0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd_q)) || (id_use_rs2 && (id_rs2 == ex_rd_q)));
    end

    // A memory wait freezes everything; a redirect squashes the hazard it would otherwise stall on.
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_redirect) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    always_comb begin
        ex_v_d      = ex_v_q;
        ex_rd_d     = ex_rd_q;
        ex_we_d     = ex_we_q;
        ex_ld_d     = ex_ld_q;
        mem_v_d     = mem_v_q;
        mem_rd_d    = mem_rd_q;
        mem_we_d    = mem_we_q;
        fwd_a_sel_d = fwd_a_sel_q;
        fwd_b_sel_d = fwd_b_sel_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_stall) begin
            mem_v_d  = ex_v_q;
            mem_rd_d = ex_rd_q;
            mem_we_d = ex_we_q;
            if (flush_ex) begin
                ex_v_d      = 1'b0;
                ex_we_d     = 1'b0;
                ex_ld_d     = 1'b0;
                fwd_a_sel_d = 2'b00;
                fwd_b_sel_d = 2'b00;
            end else begin
                ex_v_d      = id_valid;
                ex_rd_d     = id_rd;
                ex_we_d     = id_we && id_valid;
                ex_ld_d     = id_is_load && id_valid;
                fwd_a_sel_d = select_src(id_use_rs1, id_rs1, ex_v_q, ex_we_q, ex_rd_q,
                                         mem_v_q, mem_we_q, mem_rd_q);
                fwd_b_sel_d = select_src(id_use_rs2, id_rs2, ex_v_q, ex_we_q, ex_rd_q,
                                         mem_v_q, mem_we_q, mem_rd_q);
            end
            if (load_use && !ex_redirect && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= '0;
            ex_we_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_we_q    <= 1'b0;
            fwd_a_sel_q <= 2'b00;
            fwd_b_sel_q <= 2'b00;
            stall_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            ex_we_q     <= ex_we_d;
            ex_ld_q     <= ex_ld_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_we_q    <= mem_we_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the EX-stage operand muxes.
- Tracks destination registers of in-flight instructions in internal EX/MEM shadow registers.
- Produces registered 2-bit operand selects for the 3:1 operand muxes (00 regfile, 01 WB result, 10 MEM result).
- Produces combinational stall and flush controls for load-use hazards, EX-stage redirects and memory wait states.

Parameters:
- RAW, 5, register index width (32 architectural registers).
- CNTW, 32, width of the load-use stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  RAW  ID source register 1.
- id_rs2  in  RAW  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  RAW  ID destination register.
- id_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- ex_redirect  in  1  branch/jump taken in EX this cycle.
- mem_stall  in  1  data memory not ready; whole pipe freezes.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF/ID register.
- flush_id  out  1  clear IF/ID register to bubble.
- flush_ex  out  1  load bubble into ID/EX register.
- fwd_a_sel  out  2  EX operand A mux select, registered.
- fwd_b_sel  out  2  EX operand B mux select, registered.
- stall_cnt  out  CNTW  count of load-use stall cycles, saturating.

Behaviour:
- Internal state:
  - ex_v, ex_rd, ex_we, ex_ld: shadow of the instruction in EX.
  - mem_v, mem_rd, mem_we: shadow of the instruction in MEM.
  - fwd_a_sel, fwd_b_sel, stall_cnt.
- Reset (rst=1 at an edge): all state and registered outputs go to 0. Combinational outputs evaluate from that zeroed state; with id_valid=0 they are 0.
- Register x0 (index 0) never matches: it produces no forwarding and no load-use hazard.
- Load-use hazard (lu), combinational:
  - lu = id_valid & ex_v & ex_ld & ex_we & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Combinational output priority (highest first):
  1. mem_stall=1: stall_if=1, stall_id=1, flush_id=0, flush_ex=0. ex_redirect is ignored; its source must hold it until mem_stall drops.
  2. ex_redirect=1: flush_id=1, flush_ex=1, stall_if=0, stall_id=0. Redirect overrides lu.
  3. lu=1: stall_if=1, stall_id=1, flush_ex=1, flush_id=0.
  4. Otherwise all four are 0.
- Sequential update at each clk edge (rst=0):
  - mem_stall=1: all state holds, including selects and counter.
  - Otherwise MEM shadow <= EX shadow (mem_v<=ex_v, mem_rd<=ex_rd, mem_we<=ex_we).
  - If flush_ex=1: ex_v<=0, ex_we<=0, ex_ld<=0, fwd_a_sel<=00, fwd_b_sel<=00.
  - Else: ex_v<=id_valid, ex_rd<=id_rd, ex_we<=id_we&id_valid, ex_ld<=id_is_load&id_valid, and selects are computed per operand X (rs1 for A, rs2 for B):
    - 10 if use_X & ex_v & ex_we & ex_rd!=0 & rsX==ex_rd (producer moves to MEM next cycle).
    - else 01 if use_X & mem_v & mem_we & mem_rd!=0 & rsX==mem_rd (producer moves to WB).
    - else 00.
    - The younger producer (EX) wins over MEM.
  - stall_cnt increments by 1 on every edge where lu=1, mem_stall=0 and ex_redirect=0. It saturates at all-ones.
- Latency:
  - Selects are valid in the cycle the consuming instruction occupies EX, i.e. one cycle after it was in ID.
  - Stall/flush outputs are zero-latency combinational.
- Writes from WB to an instruction currently in ID are covered by the write-through register file, not by this block.
- Reset asserted mid-stall or mid-redirect clears all shadows. The first instruction after reset sees selects of 00.

Test Plan:
- EX→EX forward: ADD x5 in ID, next cycle SUB x6,x5,x1 in ID; id_valid continuous -> in the SUB's EX cycle fwd_a_sel=10, fwd_b_sel=00, no stall.
- MEM→EX forward: ADD x5, NOP, then OR x7,x2,x5 -> in the OR's EX cycle fwd_b_sel=01; with ADD x5 followed by ADD x5 then use x5, fwd_a_sel=10 (younger wins).
- Load-use: LW x8 followed by ADD x9,x8,x8 -> one cycle with stall_if=stall_id=flush_ex=1. The ADD then enters EX with fwd_a_sel=fwd_b_sel=01 and stall_cnt=1.
- Redirect priority: same load-use pattern with ex_redirect=1 in the hazard cycle -> flush_id=flush_ex=1, stall_if=0, stall_cnt unchanged. Next EX cycle has selects=00.
- mem_stall freeze: assert mem_stall for 3 cycles during a forwarding sequence -> selects and shadows hold, stall_if=stall_id=1, ex_redirect ignored. The sequence resumes with the identical selects.
- x0 and reset: LW x0 then use x0 -> no stall, selects 00. Assert rst during a load-use stall -> next cycle all outputs 0 and stall_cnt=0.
